// File: rtl/uart_pkg.sv
// Shared types and defaults for the buffered UART transmit path.
// Holds the issue FSM encoding and the gap counter width.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int GAP_CNT_W      = 4;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO feeding the UART issue FSM.
// Head word is presented combinationally; occupancy is registered.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  do_wr;
  logic                  do_rd;

  // Flush wins over both ports; full/empty gate on registered count.
  assign full    = (cnt == (ADDR_WIDTH+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_wr   = wr_en && !full && !flush;
  assign do_rd   = rd_en && !empty && !flush;
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  a_cnt_range: assert property (
    @(posedge clk) disable iff (reset)
    cnt <= (ADDR_WIDTH+1)'(DEPTH)
  );

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered UART transmit request: FIFO plus one-word-at-a-time issue.
// Each word holds trans_flag until tx_done, then a fixed low gap.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int GAP_CYCLES = 1,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  flush,
  input  logic                  tx_done,
  output logic                  trans_flag,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    GAP_CNT_W'(GAP_CYCLES - 1);

  state_t                 state;
  logic [GAP_CNT_W-1:0]   gap_cnt;
  logic [DATA_WIDTH-1:0]  head;
  logic                   issue;
  logic                   can_issue;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_data (data_in),
    .rd_en   (issue),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Issue is allowed from IDLE or on the last gap cycle, so the
  // low time between back-to-back words is exactly GAP_CYCLES.
  always_comb begin
    can_issue = 1'b0;
    unique case (1'b1)
      (state == IDLE):                   can_issue = 1'b1;
      (state == GAP && gap_cnt == '0):   can_issue = 1'b1;
      default:                           can_issue = 1'b0;
    endcase
    issue = can_issue && !empty && !flush;
  end

  // Issue FSM with registered request, data and gap counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      trans_flag <= 1'b0;
      data       <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            data       <= head;
            trans_flag <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (tx_done) begin
            trans_flag <= 1'b0;
            gap_cnt    <= GAP_LOAD;
            state      <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (issue) begin
            data       <= head;
            trans_flag <= 1'b1;
            state      <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          trans_flag <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Sticky drop flag; a flush clears it and suppresses the write.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end
  end

  a_hold: assert property (
    @(posedge clk) disable iff (reset)
    (trans_flag && !tx_done) |=> (trans_flag && $stable(data))
  );

  a_fe: assert property (
    @(posedge clk) disable iff (reset)
    !(full && empty)
  );

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer with a queue-based model.
// A second instance with GAP_CYCLES=4 checks the longer gap.
module tb_uart_tx_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          flush = 1'b0;
  logic          tx_done = 1'b0;

  logic          trans_flag, full, empty, overflow;
  logic [DW-1:0] data;
  logic [AW:0]   count;
  logic          tf4, full4, empty4, ovf4;
  logic [DW-1:0] data4;
  logic [AW:0]   count4;

  int checks = 0;
  int errors = 0;

  uart_tx_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in),
    .flush(flush), .tx_done(tx_done), .trans_flag(trans_flag),
    .data(data), .full(full), .empty(empty), .count(count),
    .overflow(overflow)
  );

  uart_tx_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in),
    .flush(flush), .tx_done(tx_done), .trans_flag(tf4),
    .data(data4), .full(full4), .empty(empty4), .count(count4),
    .overflow(ovf4)
  );

  always #5 clk = ~clk;

  // Reference model for the GAP_CYCLES=1 instance: a word queue, the
  // word in flight, and the first edge at which a new issue may occur.
  logic [DW-1:0] mq[$];
  bit            m_busy;
  logic [DW-1:0] m_cur;
  bit            m_ovf;
  int            m_ready;
  int            edge_n;

  task automatic model_step(input bit r, input bit w,
                            input logic [DW-1:0] d,
                            input bit f, input bit dn);
    bit was_full, issue, done;
    edge_n++;
    if (r) begin
      mq.delete();
      m_busy = 0; m_cur = '0; m_ovf = 0; m_ready = 0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    issue = !m_busy && edge_n >= m_ready && mq.size() > 0 && !f;
    done  = m_busy && dn;
    if (done) begin
      m_busy  = 0;
      m_ready = edge_n + 1;
    end
    if (f) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      if (issue) begin
        m_cur  = mq.pop_front();
        m_busy = 1;
      end
      if (w) begin
        if (was_full) m_ovf = 1;
        else mq.push_back(d);
      end
    end
  endtask

  task automatic tick(input bit r, input bit w, input logic [DW-1:0] d,
                      input bit f, input bit dn);
    reset = r; wr_en = w; data_in = d; flush = f; tx_done = dn;
    @(posedge clk);
    model_step(r, w, d, f, dn);
    #1;
  endtask

  task automatic test_reset;
    tick(1, 0, 8'h00, 0, 0);
    checks++; if (trans_flag !== 1'b0) begin errors++;
      $display("FAIL reset_tf got %0b exp 0", trans_flag); end
    checks++; if (data !== 8'h00) begin errors++;
      $display("FAIL reset_data got %h exp 00", data); end
    checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL reset_fifo got cnt=%0d e=%0b f=%0b exp 0 1 0",
        count, empty, full); end
    checks++; if (overflow !== 1'b0 || tf4 !== 1'b0) begin errors++;
      $display("FAIL reset_ovf got ovf=%0b tf4=%0b exp 0 0",
        overflow, tf4); end
  endtask

  task automatic test_single;
    tick(1, 0, 8'h00, 0, 0);
    tick(0, 1, 8'hA5, 0, 0);
    checks++; if (trans_flag !== 1'b0 || count !== 5'd1) begin errors++;
      $display("FAIL single_e0 got tf=%0b cnt=%0d exp 0 1",
        trans_flag, count); end
    tick(0, 0, 8'h00, 0, 0);
    checks++; if (trans_flag !== 1'b1 || data !== 8'hA5) begin errors++;
      $display("FAIL single_e1 got tf=%0b d=%h exp 1 a5",
        trans_flag, data); end
    for (int i = 0; i < 8; i++) tick(0, 0, 8'h00, 0, 0);
    checks++; if (trans_flag !== 1'b1 || data !== 8'hA5) begin errors++;
      $display("FAIL single_hold got tf=%0b d=%h exp 1 a5",
        trans_flag, data); end
    tick(0, 0, 8'h00, 0, 1);
    checks++; if (trans_flag !== 1'b0 || count !== 5'd0 || empty !== 1'b1)
    begin errors++; $display("FAIL single_done got tf=%0b cnt=%0d e=%0b exp 0 0 1",
        trans_flag, count, empty); end
  endtask

  task automatic test_three_words;
    logic [DW-1:0] w [3];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
    tick(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 1, w[i], 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (trans_flag !== 1'b1 || data !== w[k] || count !== 5'(2 - k))
      begin errors++; $display("FAIL three_word%0d got tf=%0b d=%h cnt=%0d exp 1 %h %0d",
          k, trans_flag, data, count, w[k], 2 - k); end
      tick(0, 0, 8'h00, 0, 1);
      checks++; if (trans_flag !== 1'b0) begin errors++;
        $display("FAIL three_gap%0d got tf=%0b exp 0", k, trans_flag); end
      if (k < 2) tick(0, 0, 8'h00, 0, 0);
    end
    tick(0, 0, 8'h00, 0, 0);
    checks++; if (trans_flag !== 1'b0 || empty !== 1'b1) begin errors++;
      $display("FAIL three_end got tf=%0b e=%0b exp 0 1",
        trans_flag, empty); end
  endtask

  task automatic test_overflow;
    logic [DW-1:0] w [DEPTH+2];
    int issued;
    tick(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) begin
      w[i] = 8'($urandom);
      tick(0, 1, w[i], 0, 0);
    end
    checks++; if (count !== 5'(DEPTH) || full !== 1'b1 || overflow !== 1'b1)
    begin errors++; $display("FAIL ovf_fill got cnt=%0d f=%0b o=%0b exp %0d 1 1",
        count, full, overflow, DEPTH); end
    tick(0, 0, 8'h00, 0, 0);
    checks++; if (overflow !== 1'b1) begin errors++;
      $display("FAIL ovf_sticky got %0b exp 1", overflow); end
    issued = 0;
    for (int g = 0; g < 200 && issued < DEPTH + 1; g++) begin
      if (trans_flag === 1'b1) begin
        checks++; if (data !== w[issued]) begin errors++;
          $display("FAIL ovf_drain%0d got %h exp %h", issued, data,
            w[issued]); end
        issued++;
        tick(0, 0, 8'h00, 0, 1);
      end else begin
        tick(0, 0, 8'h00, 0, 0);
      end
    end
    tick(0, 0, 8'h00, 0, 0);
    checks++; if (issued != DEPTH + 1 || trans_flag !== 1'b0 ||
                  empty !== 1'b1 || overflow !== 1'b1) begin errors++;
      $display("FAIL ovf_drain_end got n=%0d tf=%0b e=%0b o=%0b exp %0d 0 1 1",
        issued, trans_flag, empty, overflow, DEPTH + 1); end
  endtask

  task automatic test_full_pop;
    logic [DW-1:0] w [DEPTH+1];
    tick(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      w[i] = 8'($urandom);
      tick(0, 1, w[i], 0, 0);
    end
    checks++; if (full !== 1'b1 || overflow !== 1'b0) begin errors++;
      $display("FAIL fp_fill got f=%0b o=%0b exp 1 0", full, overflow); end
    tick(0, 0, 8'h00, 0, 1);
    tick(0, 1, 8'hEE, 0, 0);
    checks++; if (count !== 5'(DEPTH - 1) || overflow !== 1'b1) begin
      errors++; $display("FAIL fp_same got cnt=%0d o=%0b exp %0d 1",
        count, overflow, DEPTH - 1); end
    checks++; if (trans_flag !== 1'b1 || data !== w[1]) begin errors++;
      $display("FAIL fp_issue got tf=%0b d=%h exp 1 %h",
        trans_flag, data, w[1]); end
  endtask

  task automatic test_flush;
    logic [DW-1:0] first;
    tick(1, 0, 8'h00, 0, 0);
    first = 8'($urandom);
    tick(0, 1, first, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) tick(0, 1, 8'($urandom), 0, 0);
    tick(0, 1, 8'h77, 1, 0);
    checks++; if (count !== 5'd0 || overflow !== 1'b0) begin errors++;
      $display("FAIL flush_clr got cnt=%0d o=%0b exp 0 0",
        count, overflow); end
    checks++; if (trans_flag !== 1'b1 || data !== first) begin errors++;
      $display("FAIL flush_keep got tf=%0b d=%h exp 1 %h",
        trans_flag, data, first); end
    for (int i = 0; i < 5; i++) tick(0, 1, 8'($urandom), 0, 0);
    checks++; if (count !== 5'd5) begin errors++;
      $display("FAIL flush_q5 got %0d exp 5", count); end
    tick(0, 1, 8'h99, 1, 0);
    tick(0, 1, 8'h98, 1, 0);
    checks++; if (count !== 5'd0 || overflow !== 1'b0 ||
                  trans_flag !== 1'b1 || data !== first) begin errors++;
      $display("FAIL flush_wr got cnt=%0d o=%0b tf=%0b d=%h exp 0 0 1 %h",
        count, overflow, trans_flag, data, first); end
    tick(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) tick(0, 0, 8'h00, 0, 0);
    checks++; if (trans_flag !== 1'b0 || empty !== 1'b1) begin errors++;
      $display("FAIL flush_noissue got tf=%0b e=%0b exp 0 1",
        trans_flag, empty); end
  endtask

  task automatic test_reset_mid;
    tick(1, 0, 8'h00, 0, 0);
    tick(0, 1, 8'h3C, 0, 0);
    tick(0, 1, 8'h4D, 0, 0);
    tick(1, 0, 8'h00, 0, 0);
    checks++; if (trans_flag !== 1'b0 || data !== 8'h00 ||
                  count !== 5'd0 || empty !== 1'b1) begin errors++;
      $display("FAIL rst_busy got tf=%0b d=%h cnt=%0d e=%0b exp 0 00 0 1",
        trans_flag, data, count, empty); end
    tick(0, 1, 8'h3C, 0, 0);
    tick(0, 1, 8'h4D, 0, 0);
    tick(0, 0, 8'h00, 0, 1);
    tick(1, 0, 8'h00, 0, 0);
    checks++; if (tf4 !== 1'b0 || data4 !== 8'h00 || count4 !== 5'd0 ||
                  ovf4 !== 1'b0 || full4 !== 1'b0 || empty4 !== 1'b1)
    begin errors++; $display("FAIL rst_gap got tf=%0b d=%h cnt=%0d exp 0 00 0",
        tf4, data4, count4); end
    checks++; if (trans_flag !== 1'b0 || data !== 8'h00 || count !== 5'd0)
    begin errors++; $display("FAIL rst_gap1 got tf=%0b d=%h cnt=%0d exp 0 00 0",
        trans_flag, data, count); end
  endtask

  task automatic test_idle_done;
    tick(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 8'h00, 0, 1);
    checks++; if (trans_flag !== 1'b0 || count !== 5'd0) begin errors++;
      $display("FAIL idle_done got tf=%0b cnt=%0d exp 0 0",
        trans_flag, count); end
    tick(0, 1, 8'h5A, 0, 1);
    tick(0, 0, 8'h00, 0, 1);
    checks++; if (trans_flag !== 1'b1 || data !== 8'h5A) begin errors++;
      $display("FAIL idle_issue got tf=%0b d=%h exp 1 5a",
        trans_flag, data); end
  endtask

  task automatic test_gap4;
    int low;
    tick(1, 0, 8'h00, 0, 0);
    tick(0, 1, 8'hC1, 0, 0);
    tick(0, 1, 8'hC2, 0, 0);
    tick(0, 0, 8'h00, 0, 1);
    low = 0;
    for (int g = 0; g < 20; g++) begin
      if (tf4 === 1'b1) break;
      low++;
      tick(0, 0, 8'h00, 0, 0);
    end
    checks++; if (low != 4 || tf4 !== 1'b1 || data4 !== 8'hC2) begin
      errors++; $display("FAIL gap4 got low=%0d tf=%0b d=%h exp 4 1 c2",
        low, tf4, data4); end
  endtask

  task automatic test_random;
    bit w, f, dn;
    tick(1, 0, 8'h00, 0, 0);
    for (int c = 0; c < 600; c++) begin
      w  = ($urandom_range(0, 99) < 55);
      f  = ($urandom_range(0, 59) == 0);
      dn = m_busy ? ($urandom_range(0, 3) == 0)
                  : ($urandom_range(0, 7) == 0);
      tick(0, w, 8'($urandom), f, dn);
      checks++; if (trans_flag !== m_busy) begin errors++;
        $display("FAIL rnd_tf c=%0d got %0b exp %0b", c, trans_flag,
          m_busy); end
      checks++; if (count !== 5'(mq.size())) begin errors++;
        $display("FAIL rnd_cnt c=%0d got %0d exp %0d", c, count,
          mq.size()); end
      checks++; if (full !== (mq.size() == DEPTH) ||
                    empty !== (mq.size() == 0)) begin errors++;
        $display("FAIL rnd_fe c=%0d got f=%0b e=%0b size %0d", c, full,
          empty, mq.size()); end
      checks++; if (overflow !== m_ovf) begin errors++;
        $display("FAIL rnd_ovf c=%0d got %0b exp %0b", c, overflow,
          m_ovf); end
      if (m_busy) begin
        checks++; if (data !== m_cur) begin errors++;
          $display("FAIL rnd_data c=%0d got %h exp %h", c, data,
            m_cur); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three_words();
    test_overflow();
    test_full_pop();
    test_flush();
    test_reset_mid();
    test_idle_done();
    test_gap4();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
